// File: rtl/cache_pkg.sv
// Shared types and sizing for the cache line sequencer: line geometry,
// address and word-index typedefs, and the sequencer FSM state encoding.
package cache_pkg;

    localparam int ADDR           = 25;
    localparam int LINE           = 6;
    localparam int WORDS_PER_LINE = 32;
    localparam int WORD_IDX_W     = $clog2(WORDS_PER_LINE);

    typedef logic [ADDR-LINE-1:0]  line_addr_t;
    typedef logic [WORD_IDX_W-1:0] word_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_CAP,
        WR_REQ,
        WR_DATA,
        WR_DONE,
        RD_REQ,
        RD_DATA,
        RD_DONE
    } seq_state_t;

endpackage

// File: rtl/line_buffer.sv
// One cache line of write-back data: synchronous write from the capture
// path, asynchronous read so the SDRAM side sees the word at rptr immediately.
module line_buffer
    import cache_pkg::*;
(
    input  logic        ddr_clk,
    input  logic        we,
    input  word_idx_t   waddr,
    input  logic [15:0] wdata,
    input  word_idx_t   raddr,
    output logic [15:0] rdata
);

    logic [15:0] mem [WORDS_PER_LINE];

    always_ff @(posedge ddr_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cache_line_sequencer.sv
// Turns cache write-back/fill level requests into 32-word SDRAM bursts,
// draining victim lines into a local buffer and forwarding fill data.
module cache_line_sequencer
    import cache_pkg::*;
#(
    parameter int ADDR_W  = ADDR,
    parameter int LINE_W  = LINE,
    parameter int CRD_LAT = 2
) (
    input  logic                     ddr_clk,
    input  logic                     rst,
    input  logic                     ddr_wr,
    input  logic                     ddr_rd,
    input  logic [ADDR_W-LINE_W-1:0] hiaddr,
    input  logic [15:0]              ddr_dout,
    output logic [15:0]              ddr_din,
    output logic                     cache_read_data,
    output logic                     cache_write_data,
    output logic                     sdr_req,
    output logic                     sdr_we,
    output logic [ADDR_W-2:0]        sdr_addr,
    input  logic                     sdr_ack,
    output logic [15:0]              sdr_wdata,
    input  logic                     sdr_wdata_rd,
    input  logic [15:0]              sdr_rdata,
    input  logic                     sdr_rdata_valid,
    output logic                     busy
);

    localparam int        LA_W  = ADDR_W - LINE_W;
    localparam int        OFF_W = LINE_W - 1;
    localparam word_idx_t LAST  = word_idx_t'(WORDS_PER_LINE - 1);

    logic            wr_meta, wr_s, rd_meta, rd_s;
    logic [LA_W-1:0] hiaddr_meta, hiaddr_s, line_addr;
    seq_state_t      state;
    word_idx_t       str_cnt, wptr, rptr, rd_cnt;
    logic [CRD_LAT-1:0] cap_pipe;
    logic            cap_we;

    // Requests come from the cache clock domain; hiaddr is held stable
    // while a request is up, so a plain two-stage bus register suffices.
    always_ff @(posedge ddr_clk) begin
        if (rst) begin
            wr_meta     <= 1'b0;
            wr_s        <= 1'b0;
            rd_meta     <= 1'b0;
            rd_s        <= 1'b0;
            hiaddr_meta <= '0;
            hiaddr_s    <= '0;
        end else begin
            wr_meta     <= ddr_wr;
            wr_s        <= wr_meta;
            rd_meta     <= ddr_rd;
            rd_s        <= rd_meta;
            hiaddr_meta <= hiaddr;
            hiaddr_s    <= hiaddr_meta;
        end
    end

    // Delayed copy of the read strobe marks the cycle its word is valid.
    always_ff @(posedge ddr_clk) begin
        if (rst) begin
            cap_pipe <= '0;
        end else begin
            cap_pipe[0] <= cache_read_data;
            for (int i = 1; i < CRD_LAT; i++) begin
                cap_pipe[i] <= cap_pipe[i-1];
            end
        end
    end

    assign cap_we   = cap_pipe[CRD_LAT-1] && (state == WR_CAP);
    assign sdr_addr = {line_addr, {OFF_W{1'b0}}};

    line_buffer u_line_buffer (
        .ddr_clk (ddr_clk),
        .we      (cap_we),
        .waddr   (wptr),
        .wdata   (ddr_dout),
        .raddr   (rptr),
        .rdata   (sdr_wdata)
    );

    always_ff @(posedge ddr_clk) begin
        if (rst) begin
            state            <= IDLE;
            line_addr        <= '0;
            str_cnt          <= '0;
            wptr             <= '0;
            rptr             <= '0;
            rd_cnt           <= '0;
            cache_read_data  <= 1'b0;
            cache_write_data <= 1'b0;
            sdr_req          <= 1'b0;
            sdr_we           <= 1'b0;
            ddr_din          <= '0;
            busy             <= 1'b0;
        end else begin
            cache_write_data <= 1'b0;
            case (state)
                IDLE: begin
                    str_cnt <= '0;
                    wptr    <= '0;
                    rptr    <= '0;
                    rd_cnt  <= '0;
                    if (wr_s) begin
                        line_addr       <= hiaddr_s;
                        cache_read_data <= 1'b1;
                        busy            <= 1'b1;
                        state           <= WR_CAP;
                    end else if (rd_s) begin
                        line_addr <= hiaddr_s;
                        busy      <= 1'b1;
                        state     <= RD_REQ;
                    end
                end
                WR_CAP: begin
                    if (cache_read_data) begin
                        str_cnt <= str_cnt + 1'b1;
                        if (str_cnt == LAST) begin
                            cache_read_data <= 1'b0;
                        end
                    end
                    if (cap_we) begin
                        wptr <= wptr + 1'b1;
                        if (wptr == LAST) begin
                            state <= WR_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (!sdr_req) begin
                        sdr_req <= 1'b1;
                        sdr_we  <= 1'b1;
                    end else if (sdr_ack) begin
                        sdr_req <= 1'b0;
                        sdr_we  <= 1'b0;
                        state   <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (sdr_wdata_rd) begin
                        rptr <= rptr + 1'b1;
                        if (rptr == LAST) begin
                            state <= WR_DONE;
                        end
                    end
                end
                // A fill that follows a write-back is picked up again from IDLE.
                WR_DONE: begin
                    if (!wr_s) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RD_REQ: begin
                    if (!sdr_req) begin
                        sdr_req <= 1'b1;
                        sdr_we  <= 1'b0;
                    end else if (sdr_ack) begin
                        sdr_req <= 1'b0;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (sdr_rdata_valid) begin
                        ddr_din          <= sdr_rdata;
                        cache_write_data <= 1'b1;
                        rd_cnt           <= rd_cnt + 1'b1;
                        if (rd_cnt == LAST) begin
                            state <= RD_DONE;
                        end
                    end
                end
                RD_DONE: begin
                    if (!rd_s) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_sequencer.sv
// Self-checking bench: directed scenarios plus randomized bursts, with a
// cache model supplying victim words and an SDRAM model driving the handshake.
module tb_cache_line_sequencer;

    logic        ddr_clk = 1'b0;
    logic        rst = 1'b1;
    logic        ddr_wr = 1'b0;
    logic        ddr_rd = 1'b0;
    logic [18:0] hiaddr = '0;
    logic [15:0] ddr_dout = '0;
    logic [15:0] ddr_din;
    logic        cache_read_data, cache_write_data;
    logic        sdr_req, sdr_we;
    logic [23:0] sdr_addr;
    logic        sdr_ack = 1'b0;
    logic [15:0] sdr_wdata;
    logic        sdr_wdata_rd = 1'b0;
    logic [15:0] sdr_rdata = '0;
    logic        sdr_rdata_valid = 1'b0;
    logic        busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [15:0] cache_line [32];
    logic [15:0] fill_words [32];
    logic [15:0] fill_q [$];
    int          line_idx = 0, i0 = 0, i1 = 0, i2 = 0;
    logic        h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;
    int          rd_strobe_cnt = 0;
    int          req_rise_cnt = 0;
    logic        req_prev = 1'b0;

    always #5 ddr_clk = ~ddr_clk;

    cache_line_sequencer dut (
        .ddr_clk          (ddr_clk),
        .rst              (rst),
        .ddr_wr           (ddr_wr),
        .ddr_rd           (ddr_rd),
        .hiaddr           (hiaddr),
        .ddr_dout         (ddr_dout),
        .ddr_din          (ddr_din),
        .cache_read_data  (cache_read_data),
        .cache_write_data (cache_write_data),
        .sdr_req          (sdr_req),
        .sdr_we           (sdr_we),
        .sdr_addr         (sdr_addr),
        .sdr_ack          (sdr_ack),
        .sdr_wdata        (sdr_wdata),
        .sdr_wdata_rd     (sdr_wdata_rd),
        .sdr_rdata        (sdr_rdata),
        .sdr_rdata_valid  (sdr_rdata_valid),
        .busy             (busy)
    );

    // Cache model: the k-th read strobe of a line yields cache_line[k] two
    // cycles later; all other cycles carry junk. Also records fill strobes.
    always @(negedge ddr_clk) begin
        if (rst) begin
            h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
            line_idx = 0;
        end else begin
            h2 = h1; i2 = i1;
            h1 = h0; i1 = i0;
            h0 = cache_read_data; i0 = line_idx;
            if (cache_read_data) begin
                line_idx = (line_idx + 1) % 32;
                rd_strobe_cnt++;
            end
        end
        ddr_dout = h2 ? cache_line[i2] : 16'($urandom);
        if (cache_write_data) fill_q.push_back(ddr_din);
        if (sdr_req && !req_prev) req_rise_cnt++;
        req_prev = sdr_req;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ddr_clk);
        #1;
    endtask

    task automatic waitBusyLow(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(busy), 32'd0);
        repeat (2) tick();
    endtask

    task automatic sdramHandshake(input string tag, input logic we, input logic [23:0] addr, input int stall);
        int   n = 0;
        logic held = 1'b1;
        while (!sdr_req && n < 300) begin
            tick();
            n++;
        end
        checkOutput({tag, "_req"}, 32'(sdr_req), 32'd1);
        checkOutput({tag, "_we"}, 32'(sdr_we), 32'(we));
        checkOutput({tag, "_addr"}, 32'(sdr_addr), 32'(addr));
        repeat (stall) begin
            tick();
            if (!sdr_req) held = 1'b0;
        end
        checkOutput({tag, "_held"}, 32'(held), 32'd1);
        sdr_ack = 1'b1;
        tick();
        sdr_ack = 1'b0;
        checkOutput({tag, "_drop"}, 32'(sdr_req), 32'd0);
    endtask

    task automatic runWriteBack(input logic [18:0] addr, input int stall, input int gap,
                                input bit extra, input bit drop_after);
        int          n = 0;
        int          base = rd_strobe_cnt;
        int          rise = req_rise_cnt;
        logic [15:0] got [$];
        hiaddr = addr;
        ddr_wr = 1'b1;
        while (!cache_read_data && n < 20) begin
            tick();
            n++;
        end
        checkOutput("wr_latency", 32'(n), 32'd3);
        sdramHandshake("wr", 1'b1, {addr, 5'b0}, stall);
        checkOutput("wr_strobes", 32'(rd_strobe_cnt - base), 32'd32);
        for (int k = 0; k < 32 + int'(extra); k++) begin
            repeat (gap) tick();
            if (k < 32) got.push_back(sdr_wdata);
            sdr_wdata_rd = 1'b1;
            tick();
            sdr_wdata_rd = 1'b0;
        end
        repeat (2) tick();
        checkOutput("wr_done_busy", 32'(busy), 32'd1);
        checkOutput("wr_no_extra_strobe", 32'(rd_strobe_cnt - base), 32'd32);
        for (int k = 0; k < 32; k++) begin
            checkOutput($sformatf("wr_word%0d", k), 32'(got[k]), 32'(cache_line[k]));
        end
        if (drop_after) begin
            ddr_wr = 1'b0;
            waitBusyLow("wr_idle");
            repeat (4) tick();
            checkOutput("wr_one_req", 32'(req_rise_cnt - rise), 32'd1);
        end
    endtask

    task automatic runFill(input logic [18:0] addr, input int stall, input int gap, input bit check_lat);
        int          n = 0;
        int          q0 = fill_q.size();
        logic [15:0] got;
        hiaddr = addr;
        ddr_wr = 1'b0;
        ddr_rd = 1'b1;
        if (check_lat) begin
            while (!sdr_req && n < 20) begin
                tick();
                n++;
            end
            checkOutput("rd_latency", 32'(n), 32'd4);
        end
        sdramHandshake("rd", 1'b0, {addr, 5'b0}, stall);
        for (int k = 0; k < 32; k++) begin
            repeat (gap) tick();
            sdr_rdata = fill_words[k];
            sdr_rdata_valid = 1'b1;
            tick();
            sdr_rdata_valid = 1'b0;
            sdr_rdata = 16'($urandom);
        end
        repeat (3) tick();
        checkOutput("rd_strobes", 32'(fill_q.size() - q0), 32'd32);
        for (int k = 0; k < 32; k++) begin
            got = (q0 + k < fill_q.size()) ? fill_q[q0 + k] : 16'hxxxx;
            checkOutput($sformatf("rd_word%0d", k), 32'(got), 32'(fill_words[k]));
        end
        ddr_rd = 1'b0;
        waitBusyLow("rd_idle");
    endtask

    task automatic applyStimulus(input int op, input int stall, input int gap);
        logic [18:0] a;
        a = 19'($urandom);
        for (int k = 0; k < 32; k++) begin
            cache_line[k] = 16'($urandom);
            fill_words[k] = 16'($urandom);
        end
        case (op)
            0: runFill(a, stall, gap, 1'b1);
            1: runWriteBack(a, stall, gap, 1'b0, 1'b1);
            default: begin
                runWriteBack(a, stall, gap, 1'b0, 1'b0);
                runFill(a + 19'd1, stall, gap, 1'b0);
            end
        endcase
    endtask

    initial begin
        int n;
        int k;
        int q0;
        repeat (3) tick();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_req", 32'(sdr_req), 32'd0);
        checkOutput("rst_we", 32'(sdr_we), 32'd0);
        checkOutput("rst_crd", 32'(cache_read_data), 32'd0);
        checkOutput("rst_cwd", 32'(cache_write_data), 32'd0);
        checkOutput("rst_din", 32'(ddr_din), 32'd0);
        checkOutput("rst_addr", 32'(sdr_addr), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Plain fill with back-to-back read data
        for (int i = 0; i < 32; i++) fill_words[i] = 16'h1000 + 16'(i);
        runFill(19'h00123, 2, 0, 1'b1);

        // Write-back followed directly by a fill of the next line
        for (int i = 0; i < 32; i++) begin
            cache_line[i] = 16'hA000 + 16'(i);
            fill_words[i] = 16'($urandom);
        end
        runWriteBack(19'h00040, 2, 0, 1'b0, 1'b0);
        runFill(19'h00041, 1, 0, 1'b0);

        // Flush: write-back with no fill behind it
        for (int i = 0; i < 32; i++) cache_line[i] = 16'($urandom);
        runWriteBack(19'($urandom), 0, 0, 1'b0, 1'b1);

        // Stalled SDRAM, spaced handshakes, and a surplus wdata_rd pulse
        for (int i = 0; i < 32; i++) begin
            cache_line[i] = 16'($urandom);
            fill_words[i] = 16'($urandom);
        end
        runWriteBack(19'h2BEEF, 20, 3, 1'b1, 1'b1);
        runFill(19'h1CAFE, 20, 3, 1'b1);

        // Read-valid pulses while idle must be ignored
        q0 = fill_q.size();
        repeat (3) begin
            sdr_rdata = 16'($urandom);
            sdr_rdata_valid = 1'b1;
            tick();
            sdr_rdata_valid = 1'b0;
            tick();
        end
        repeat (2) tick();
        checkOutput("idle_valid_strobes", 32'(fill_q.size() - q0), 32'd0);
        checkOutput("idle_valid_busy", 32'(busy), 32'd0);
        checkOutput("idle_valid_din", 32'(ddr_din), 32'(fill_words[31]));

        // Reset while capturing word 10 of a write-back
        hiaddr = 19'h05555;
        ddr_wr = 1'b1;
        n = 0;
        k = 0;
        while (k < 11 && n < 50) begin
            tick();
            n++;
            if (cache_read_data) k++;
        end
        checkOutput("mid_rst_reached", 32'(k), 32'd11);
        rst = 1'b1;
        ddr_wr = 1'b0;
        tick();
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_crd", 32'(cache_read_data), 32'd0);
        checkOutput("mid_rst_cwd", 32'(cache_write_data), 32'd0);
        checkOutput("mid_rst_req", 32'(sdr_req), 32'd0);
        checkOutput("mid_rst_we", 32'(sdr_we), 32'd0);
        checkOutput("mid_rst_din", 32'(ddr_din), 32'd0);
        checkOutput("mid_rst_addr", 32'(sdr_addr), 32'd0);
        rst = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 32; i++) cache_line[i] = 16'($urandom);
        runWriteBack(19'h05556, 1, 1, 1'b0, 1'b1);

        for (int t = 0; t < 8; t++) begin
            applyStimulus($urandom_range(0, 2), $urandom_range(0, 8), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/cache_line_sequencer.md
# cache_line_sequencer

Bridges the cache controller's RAM side to the SDRAM controller's word-burst port, in the `ddr_clk` domain. It turns the level requests `ddr_wr`/`ddr_rd` plus `hiaddr` into 32-word SDRAM bursts. On write-back it first drains the victim line into a local line buffer by strobing `cache_read_data`; on fill it forwards SDRAM read data to the cache with `cache_write_data`. It keeps the cache's internal 32-word line counter in step by issuing exactly 32 strobes per phase.

## Interface
Parameters:
- `ADDR_W`, 25: byte address width.
- `LINE_W`, 6: log2 bytes per line; line = 2^(LINE_W-1) = 32 words.
- `CRD_LAT`, 2: `ddr_clk` cycles from a `cache_read_data` strobe to valid `ddr_dout`.

Ports:
- `ddr_clk`, in, 1: sole clock. One clock; reset is synchronous and active-high.
- `rst`, in, 1: synchronous, active-high reset.
- `ddr_wr`, in, 1: write-back request level from the cache (`clk` domain).
- `ddr_rd`, in, 1: fill request level from the cache (`clk` domain).
- `hiaddr`, in, ADDR_W-LINE_W (19): line address.
- `ddr_dout`, in, 16: word read out of the cache.
- `ddr_din`, out, 16: word to write into the cache.
- `cache_read_data`, out, 1: cache read strobe.
- `cache_write_data`, out, 1: cache write strobe.
- `sdr_req`, out, 1: burst request.
- `sdr_we`, out, 1: 1 = write burst.
- `sdr_addr`, out, ADDR_W-1 (24): word address = {line, 5'b0}.
- `sdr_ack`, in, 1: request accepted.
- `sdr_wdata`, out, 16: current write word.
- `sdr_wdata_rd`, in, 1: write word consumed; advance.
- `sdr_rdata`, in, 16: read word.
- `sdr_rdata_valid`, in, 1: read word valid.
- `busy`, out, 1: high whenever state ≠ IDLE.

## Operation
Synchronisation:
- `ddr_wr` and `ddr_rd` each pass through a 2-flop synchroniser, giving `wr_s` and `rd_s`.
- `hiaddr` is registered twice as a bus, giving `hiaddr_s`. The cache holds it stable while a request is asserted.

FSM states and transitions:
- IDLE
  - If `wr_s`: latch `hiaddr_s`, go to WR_CAP. `wr_s` has priority over `rd_s`.
  - Else if `rd_s`: latch `hiaddr_s`, go to RD_REQ.
- WR_CAP
  - Assert `cache_read_data` for exactly 32 consecutive cycles.
  - Each `ddr_dout` is written to the line buffer CRD_LAT cycles after its strobe, at write index 0..31.
  - Go to WR_REQ after the 32nd capture.
- WR_REQ
  - Hold `sdr_req`=1, `sdr_we`=1 and `sdr_addr` until `sdr_ack`, then go to WR_DATA.
- WR_DATA
  - `sdr_wdata` = buffer[rptr] combinationally.
  - `rptr` increments on each `sdr_wdata_rd`.
  - Go to WR_DONE when the 32nd word is consumed. Further `sdr_wdata_rd` pulses are ignored.
- WR_DONE
  - Wait for `wr_s`=0, then go to IDLE. A following fill re-qualifies there. This covers the flush case, where no fill follows.
- RD_REQ
  - Same handshake as WR_REQ with `sdr_we`=0, then go to RD_DATA.
- RD_DATA
  - Each `sdr_rdata_valid` registers `ddr_din`←`sdr_rdata` and pulses `cache_write_data` on the next cycle.
  - Count 32 valid words, then go to RD_DONE.
- RD_DONE
  - Wait for `rd_s`=0, then go to IDLE.

Other rules:
- `sdr_rdata_valid` outside RD_DATA is ignored; no strobe is produced.
- The strobe count per phase is always exactly 32, so the cache's 5-bit counter returns to 0.
- Reset mid-operation:
  - FSM goes to IDLE, counters clear, buffer contents become don't-care.
  - `rst` must coincide with the cache controller's own initialisation; the two line counters are not resynchronised otherwise.

## Timing
- Reset values:
  - `sdr_req`, `sdr_we`, `cache_read_data`, `cache_write_data`, `busy` = 0.
  - `ddr_din` = 0, `sdr_addr` = 0.
  - `sdr_wdata` = buffer[0], don't-care.
- Request to first action:
  - `ddr_wr` rise to first `cache_read_data`: 3 cycles (2 synchroniser + 1 IDLE decision).
  - `ddr_rd` rise to `sdr_req`: 4 cycles.
- Capture completes CRD_LAT cycles after the last strobe. `sdr_req` rises on the following cycle.
- `sdr_rdata_valid` to `cache_write_data`: 1 cycle. Back-to-back valid words give back-to-back strobes.
- `sdr_req` stays high through the `sdr_ack` cycle and drops the cycle after.

## Structure
- Shared package `cache_pkg`:
  - `ADDR`, `LINE`, `WORDS_PER_LINE` = 32.
  - The FSM state enum `seq_state_t`.
  - Line-address typedef `line_addr_t` (19 bits).
- Sub-module `line_buffer`: 32×16 memory with one synchronous write port and one asynchronous read port.

## Test plan
1. **Plain fill.** Raise `ddr_rd` with `hiaddr`=19'h00123; SDRAM returns words 0x1000..0x101F, one per cycle.
   - Expect `sdr_addr`=24'h002460, `sdr_we`=0.
   - Expect 32 `cache_write_data` strobes carrying 0x1000..0x101F in order.
2. **Write-back then fill.** Raise `ddr_wr` (hiaddr 0x00040), cache model returns 0xA000+k. Then drop `ddr_wr`, raise `ddr_rd` with hiaddr 0x00041.
   - Expect 32 `cache_read_data` strobes.
   - Expect SDRAM write to 24'h000800 of 0xA000..0xA01F.
   - Then a read burst at 24'h000820.
3. **Flush write.** Raise `ddr_wr` only.
   - Expect a write burst, return to IDLE after `ddr_wr` falls, no read request.
4. **Stalled SDRAM.** Hold `sdr_ack` low for 20 cycles; space `sdr_wdata_rd` and `sdr_rdata_valid` 3 cycles apart.
   - Expect `sdr_req` held throughout the stall.
   - Expect data order unchanged and exactly 32 strobes.
5. **Spurious and extra inputs.** Pulse `sdr_rdata_valid` in IDLE; apply a 33rd `sdr_wdata_rd`.
   - Expect no strobes and no state change.
6. **Reset mid-operation.** Assert `rst` during WR_CAP word 10.
   - Expect all outputs 0 the next cycle, FSM in IDLE, and `busy`=0.
